// File: rtl/gen_ps2_pkg.sv
// Shared constants for the PS/2 mouse receiver: bit-receiver states, frame bit
// positions, MOUSE vector field offsets and status-byte bit positions.
package gen_ps2_pkg;

    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_SHIFT = 1'b1;

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_PAR   = 4'd9;
    localparam logic [3:0] BIT_STOP  = 4'd10;

    localparam int unsigned MOUSE_TOG = 24;
    localparam int unsigned MOUSE_DY  = 16;
    localparam int unsigned MOUSE_DX  = 8;
    localparam int unsigned MOUSE_ST  = 0;

    localparam int unsigned ST_YSIGN = 5;
    localparam int unsigned ST_XSIGN = 4;
    localparam int unsigned ST_SYNC  = 3;

    // Data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit frame
// FSM and inter-edge timeout. Emits a byte with accept/abort/start-error pulses.
module ps2_rx_frame
    import gen_ps2_pkg::*;
#(
    parameter int unsigned FILT    = 4,
    parameter int unsigned BIT_TMO = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_abort,
    output logic       rx_start_err
);

    localparam int unsigned FW = $clog2(FILT + 1);
    localparam int unsigned TW = $clog2(BIT_TMO + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(BIT_TMO - 1);

    logic          clk_meta_r;
    logic          clk_sync_r;
    logic          dat_meta_r;
    logic          dat_sync_r;
    logic          filt_clk_r;
    logic [FW-1:0] filt_cnt_r;
    logic [0:0]    state_r;
    logic [3:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [TW-1:0] bit_tmr_r;
    logic          fall_s;
    logic          stop_s;
    logic          tmo_s;
    logic          frame_ok_s;

    // Two-flop synchronisers for the raw lines, free-running on every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // The filtered falling edge is the cycle in which a high filtered level flips.
    assign fall_s = ce & filt_clk_r & ~clk_sync_r & (filt_cnt_r == FILT_LAST);

    // Glitch filter: the level flips only after FILT consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= {FW{1'b0}};
        end else if (ce) begin
            if (clk_sync_r != filt_clk_r) begin
                if (filt_cnt_r == FILT_LAST) begin
                    filt_clk_r <= ~filt_clk_r;
                    filt_cnt_r <= {FW{1'b0}};
                end else begin
                    filt_cnt_r <= filt_cnt_r + FW'(1);
                end
            end else begin
                filt_cnt_r <= {FW{1'b0}};
            end
        end else begin
            filt_cnt_r <= filt_cnt_r;
        end
    end

    // Frame FSM with bit timer; a falling edge always takes priority over timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RX_IDLE;
            bit_idx_r <= BIT_START;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            bit_tmr_r <= {TW{1'b0}};
        end else if (fall_s) begin
            bit_tmr_r <= {TW{1'b0}};
            if (state_r == RX_IDLE) begin
                if (!dat_sync_r) begin
                    state_r   <= RX_SHIFT;
                    bit_idx_r <= 4'd1;
                end else begin
                    state_r   <= RX_IDLE;
                end
            end else begin
                if (bit_idx_r <= 4'd8) begin
                    shift_r <= {dat_sync_r, shift_r[7:1]};
                end else if (bit_idx_r == BIT_PAR) begin
                    par_r <= dat_sync_r;
                end else begin
                    par_r <= par_r;
                end
                if (bit_idx_r == BIT_STOP) begin
                    state_r   <= RX_IDLE;
                    bit_idx_r <= BIT_START;
                end else begin
                    bit_idx_r <= bit_idx_r + 4'd1;
                end
            end
        end else if (tmo_s) begin
            state_r   <= RX_IDLE;
            bit_idx_r <= BIT_START;
            bit_tmr_r <= {TW{1'b0}};
        end else if (ce && state_r == RX_SHIFT) begin
            bit_tmr_r <= bit_tmr_r + TW'(1);
        end else if (state_r == RX_IDLE) begin
            bit_tmr_r <= {TW{1'b0}};
        end else begin
            bit_tmr_r <= bit_tmr_r;
        end
    end

    // Frame verdicts are issued in the sampling cycle so the assembler can act on the same edge.
    always_comb begin
        stop_s       = fall_s & (state_r == RX_SHIFT) & (bit_idx_r == BIT_STOP);
        tmo_s        = ce & ~fall_s & (state_r == RX_SHIFT) & (bit_tmr_r == TMO_LAST);
        frame_ok_s   = odd_parity_ok(shift_r, par_r) & dat_sync_r;
        rx_byte      = shift_r;
        rx_vld       = stop_s & frame_ok_s;
        rx_abort     = (stop_s & ~frame_ok_s) | tmo_s;
        rx_start_err = fall_s & (state_r == RX_IDLE) & dat_sync_r;
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: assembles status/dx/dy bytes into the toggled
// 25-bit MOUSE vector and keeps a saturating error count.
module ps2_mouse_rx
    import gen_ps2_pkg::*;
#(
    parameter int unsigned FILT    = 4,
    parameter int unsigned BIT_TMO = 2000,
    parameter int unsigned PKT_TMO = 40000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [24:0] MOUSE,
    output logic        PKT_STB,
    output logic [7:0]  ERR_CNT
);

    localparam int unsigned GW = $clog2(PKT_TMO + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(PKT_TMO - 1);

    logic [7:0]    rx_byte_s;
    logic          rx_vld_s;
    logic          rx_abort_s;
    logic          rx_start_err_s;
    logic          sync_err_s;
    logic          gap_tmo_s;
    logic          err_inc_s;
    logic [1:0]    byte_idx_r;
    logic [7:0]    status_r;
    logic [7:0]    dx_r;
    logic [GW-1:0] gap_tmr_r;
    logic [24:0]   mouse_r;
    logic          pkt_stb_r;
    logic [7:0]    err_cnt_r;

    ps2_rx_frame #(
        .FILT    (FILT),
        .BIT_TMO (BIT_TMO)
    ) u_frame (
        .clk          (CLK),
        .rst_n        (RESET_N),
        .ce           (CE),
        .ps2_clk      (PS2_CLK),
        .ps2_dat      (PS2_DAT),
        .rx_byte      (rx_byte_s),
        .rx_vld       (rx_vld_s),
        .rx_abort     (rx_abort_s),
        .rx_start_err (rx_start_err_s)
    );

    // An accepted byte in the timeout cycle wins; coincident error sources count once.
    always_comb begin
        sync_err_s = rx_vld_s & (byte_idx_r == 2'd0) & ~rx_byte_s[ST_SYNC];
        gap_tmo_s  = CE & (byte_idx_r != 2'd0) & (gap_tmr_r == GAP_LAST) & ~rx_vld_s;
        err_inc_s  = rx_abort_s | rx_start_err_s | sync_err_s | gap_tmo_s;
    end

    // Packet assembler, gap timer and MOUSE output register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_idx_r <= 2'd0;
            status_r   <= 8'h00;
            dx_r       <= 8'h00;
            gap_tmr_r  <= {GW{1'b0}};
            mouse_r    <= 25'h0;
            pkt_stb_r  <= 1'b0;
        end else begin
            pkt_stb_r <= 1'b0;
            if (rx_abort_s || gap_tmo_s) begin
                byte_idx_r <= 2'd0;
                gap_tmr_r  <= {GW{1'b0}};
            end else if (rx_vld_s) begin
                gap_tmr_r <= {GW{1'b0}};
                case (byte_idx_r)
                    2'd0: begin
                        if (rx_byte_s[ST_SYNC]) begin
                            status_r   <= rx_byte_s;
                            byte_idx_r <= 2'd1;
                        end else begin
                            byte_idx_r <= 2'd0;
                        end
                    end
                    2'd1: begin
                        dx_r       <= rx_byte_s;
                        byte_idx_r <= 2'd2;
                    end
                    2'd2: begin
                        mouse_r[MOUSE_TOG]     <= ~mouse_r[MOUSE_TOG];
                        mouse_r[MOUSE_DY +: 8] <= rx_byte_s;
                        mouse_r[MOUSE_DX +: 8] <= dx_r;
                        mouse_r[MOUSE_ST +: 8] <= status_r;
                        pkt_stb_r              <= 1'b1;
                        byte_idx_r             <= 2'd0;
                    end
                    default: begin
                        byte_idx_r <= 2'd0;
                    end
                endcase
            end else if (CE && byte_idx_r != 2'd0) begin
                gap_tmr_r <= gap_tmr_r + GW'(1);
            end else begin
                gap_tmr_r <= gap_tmr_r;
            end
        end
    end

    // Saturating error counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt_r <= 8'h00;
        end else if (err_inc_s && err_cnt_r != 8'hFF) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign MOUSE   = mouse_r;
    assign PKT_STB = pkt_stb_r;
    assign ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: drives PS/2 frames and compares against a packet-level
// reference model (byte queue, toggle, saturating error count).
module tb_ps2_mouse_rx;

    localparam int unsigned FILT    = 4;
    localparam int unsigned BIT_TMO = 400;
    localparam int unsigned PKT_TMO = 4000;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CE;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic [24:0] MOUSE;
    logic        PKT_STB;
    logic [7:0]  ERR_CNT;

    int n_cmp   = 0;
    int n_bad   = 0;
    int stb_cnt = 0;
    bit slow    = 1'b0;

    logic [24:0] m_mouse;
    int          m_err;
    int          m_pkts = 0;
    logic [7:0]  m_q[$];

    ps2_mouse_rx #(
        .FILT    (FILT),
        .BIT_TMO (BIT_TMO),
        .PKT_TMO (PKT_TMO)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CE      (CE),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .MOUSE   (MOUSE),
        .PKT_STB (PKT_STB),
        .ERR_CNT (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (PKT_STB === 1'b1) stb_cnt <= stb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_reset();
        m_mouse = 25'h0;
        m_err   = 0;
        m_q.delete();
    endfunction

    function automatic void m_bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_bump();
            m_q.delete();
        end else if (m_q.size() == 0 && !b[3]) begin
            m_bump();
        end else begin
            m_q.push_back(b);
            if (m_q.size() == 3) begin
                m_mouse = {~m_mouse[24], m_q[2], m_q[1], m_q[0]};
                m_pkts++;
                m_q.delete();
            end
        end
    endfunction

    function automatic void m_gap();
        if (m_q.size() != 0) begin
            m_bump();
            m_q.delete();
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_mouse"}, {7'b0, MOUSE}, {7'b0, m_mouse});
        check({tag, "_err"}, {24'b0, ERR_CNT}, m_err);
        check({tag, "_stb"}, stb_cnt, m_pkts);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic ticks(input int n);
        repeat (n) begin
            if (slow) begin
                CE = 1'b0;
                @(negedge CLK);
            end
            CE = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            ticks(half);
            PS2_CLK = 1'b0;
            ticks(half);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    task automatic send_frame(input logic [7:0] d, input int kind, input int half);
        logic [10:0] f;
        f = {1'b1, ~^d, d, 1'b0};
        if (kind == 1) f[9] = ~f[9];
        if (kind == 2) f[10] = 1'b0;
        send_bits(f, 11, half);
        ticks(4 * half);
        m_byte(d, kind == 0);
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y, input int half);
        send_frame(s, 0, half);
        send_frame(x, 0, half);
        send_frame(y, 0, half);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [24:0] saved;
        logic [7:0]  b;
        int          half;
        int          kind;

        RESET_N = 1'b0;
        CE      = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        m_reset();
        repeat (3) @(negedge CLK);
        check("rst_mouse", {7'b0, MOUSE}, 32'h0);
        check("rst_err", {24'b0, ERR_CNT}, 32'h0);
        check("rst_stb", {31'b0, PKT_STB}, 32'h0);
        RESET_N = 1'b1;
        ticks(10);

        send_pkt(8'h08, 8'h05, 8'hFB, 30);
        check("pkt1_const", {7'b0, MOUSE}, 32'h01FB0508);
        check_model("pkt1");

        send_pkt(8'h08, 8'h05, 8'hFB, 30);
        check("pkt2_const", {7'b0, MOUSE}, 32'h00FB0508);
        check_model("pkt2");

        send_frame(8'h05, 0, 30);
        send_pkt(8'h09, 8'h01, 8'h02, 30);
        check("sync_const", {7'b0, MOUSE}, 32'h01020109);
        check("sync_err", {24'b0, ERR_CNT}, 32'h1);
        check_model("sync");

        send_frame(8'h0A, 0, 30);
        send_frame(8'h33, 1, 30);
        check_model("badpar");
        send_pkt(8'h18, 8'h7F, 8'h80, 30);
        check("badpar_const", {7'b0, MOUSE}, 32'h00807F18);
        check_model("after_badpar");

        for (int g = 0; g < 6; g++) begin
            PS2_DAT = g[0];
            PS2_CLK = 1'b0;
            ticks(FILT - 1);
            PS2_CLK = 1'b1;
            ticks(8);
        end
        PS2_DAT = 1'b1;
        ticks(20);
        check_model("glitch_idle");

        send_frame(8'h38, 0, 30);
        PS2_CLK = 1'b0;
        ticks(FILT - 1);
        PS2_CLK = 1'b1;
        ticks(10);
        send_frame(8'hF0, 0, 30);
        send_frame(8'h0F, 0, 30);
        check_model("glitch_pkt");

        send_bits(11'h14A, 5, 30);
        ticks(BIT_TMO + 50);
        m_byte(8'h00, 1'b0);
        check_model("bit_tmo");

        saved = MOUSE;
        send_frame(8'h28, 0, 30);
        ticks(PKT_TMO + 100);
        m_gap();
        check("gap_hold", {7'b0, MOUSE}, {7'b0, saved});
        check_model("gap_tmo");
        send_pkt(8'h2C, 8'h11, 8'hEE, 30);
        check_model("after_gap");

        for (int r = 0; r < 8; r++) begin
            slow = 1'($urandom_range(0, 1));
            half = $urandom_range(15, 30);
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom);
                if (k == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
                kind = $urandom_range(0, 5);
                if (kind > 2) kind = 0;
                send_frame(b, kind, half);
            end
            check_model("rand");
        end
        slow = 1'b0;

        ticks(PKT_TMO + 100);
        m_gap();
        check_model("flush");

        repeat (300) begin
            send_bits(11'h7FF, 1, 10);
            ticks(10);
            m_bump();
        end
        check("sat_const", {24'b0, ERR_CNT}, 32'd255);
        check_model("sat");

        send_bits(11'h0F0, 4, 20);
        RESET_N = 1'b0;
        #1;
        m_reset();
        check("midrst_mouse", {7'b0, MOUSE}, 32'h0);
        check("midrst_err", {24'b0, ERR_CNT}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        ticks(10);
        send_pkt(8'h0B, 8'h22, 8'h44, 25);
        check("midrst_pkt", {7'b0, MOUSE}, 32'h0144220B);
        check_model("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
